// File: rtl/alu_issue_pkg.sv
// Package shared by alu_issue and alu.
// Contents:
//   alu_op_t       - ALU opcode encodings (3-bit, shared with alu)
//   issue_entry_t  - one decoded op as buffered in the issue FIFO
//   REG_IDX_W      - register index width
//   ISSUE_XLEN     - datapath width the entry immediate is sized for
package common;

  localparam int REG_IDX_W  = 5;
  localparam int ISSUE_XLEN = 32;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3
  } alu_op_t;

  typedef struct packed {
    alu_op_t                 command;
    logic [REG_IDX_W-1:0]    rs1;
    logic [REG_IDX_W-1:0]    rs2;
    logic [REG_IDX_W-1:0]    rd;
    logic                    use_imm;
    logic [ISSUE_XLEN-1:0]   imm;
  } issue_entry_t;

endpackage

// File: rtl/alu_issue_if.sv
// Decoded-op handshake bundle between the decoder (master) and alu_issue (slave).
// Signals:
//   in_valid    master->slave  op offered
//   in_ready    slave->master  issue FIFO can accept
//   in_command  master->slave  ALU opcode
//   in_rs1/rs2/rd              register indices
//   in_use_imm                 operand B comes from in_imm
//   in_imm                     immediate
interface alu_issue_if #(
  parameter int XLEN = 32
);
  logic                          in_valid;
  logic                          in_ready;
  logic [2:0]                    in_command;
  logic [common::REG_IDX_W-1:0]  in_rs1;
  logic [common::REG_IDX_W-1:0]  in_rs2;
  logic [common::REG_IDX_W-1:0]  in_rd;
  logic                          in_use_imm;
  logic [XLEN-1:0]               in_imm;

  modport master (
    output in_valid, in_command, in_rs1, in_rs2, in_rd, in_use_imm, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_command, in_rs1, in_rs2, in_rd, in_use_imm, in_imm,
    output in_ready
  );
endinterface

// File: rtl/alu.sv
// Execute-stage ALU: registers the result of the op presented with valid.
// Undefined command encodings execute as ADD.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   valid            op present this cycle
//   command          alu_op_t opcode
//   in_a, in_b       operands
//   result           registered result, available the cycle after valid
module alu
  import common::*;
#(
  parameter int XLEN = ISSUE_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic [2:0]      command,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] result_q, result_d;

  always_comb begin
    case (command)
      ALU_AND: result_d = in_a & in_b;
      ALU_OR:  result_d = in_a | in_b;
      ALU_SUB: result_d = in_a - in_b;
      default: result_d = in_a + in_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)      result_q <= '0;
    else if (valid) result_q <= result_d;
  end

  assign result = result_q;

endmodule

// File: rtl/alu_issue_fifo.sv
// Two-entry FIFO of issue_entry_t with wrapping read/write pointers.
// Ports:
//   clk, reset   clock, synchronous active-high reset (control state only)
//   push_i       write data_i at the tail (ignored while full, even if popping)
//   data_i       entry to push
//   pop_i        drop the head entry (ignored while empty)
//   head_o       current head entry
//   full_o       both entries occupied
//   empty_o      no entries
module alu_issue_fifo
  import common::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  issue_entry_t data_i,
  input  logic         pop_i,
  output issue_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  issue_entry_t mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 2'd1;
    else if (do_pop && !do_push) count_d = count_q - 2'd1;
  end

  // Storage is not reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage in front of the execute-stage alu. Buffers decoded ops in a
// 2-entry FIFO, reads operands from a 32x32 register file (x0 = 0), resolves
// the RAW hazard against the op currently in the ALU, drives the ALU, and
// writes the ALU's registered result back one cycle after issue.
// Build option:
//   ALU_ISSUE_FWD_EN  defined   -> hazard operands forwarded from alu_result
//                     undefined -> dependent head op stalls one cycle
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   in_if (alu_issue_if.slave)     decoded-op valid/ready handshake
//   alu_valid/command/in_a/in_b    to the ALU
//   alu_result                     registered result from the ALU
//   wb_valid/wb_rd/wb_data         writeback of the op issued last cycle
module alu_issue
  import common::*;
#(
  parameter int XLEN  = ISSUE_XLEN,
  parameter int NREGS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_issue_if.slave           in_if,
  output logic                 alu_valid,
  output logic [2:0]           alu_command,
  output logic [XLEN-1:0]      alu_in_a,
  output logic [XLEN-1:0]      alu_in_b,
  input  logic [XLEN-1:0]      alu_result,
  output logic                 wb_valid,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [XLEN-1:0]      wb_data
);

  issue_entry_t         push_entry, head;
  logic                 full, empty, push, pop, stall;
  logic                 hit_a, hit_b;
  logic [XLEN-1:0]      rf_q [NREGS];
  logic                 pend_valid_q, pend_valid_d;
  logic [REG_IDX_W-1:0] pend_rd_q, pend_rd_d;
  logic [XLEN-1:0]      opnd_a, opnd_b;

  // in_ready comes straight from FIFO occupancy registers.
  assign in_if.in_ready = !full;
  assign push           = in_if.in_valid && !full;

  always_comb begin
    push_entry         = '0;
    push_entry.command = alu_op_t'(in_if.in_command);
    push_entry.rs1     = in_if.in_rs1;
    push_entry.rs2     = in_if.in_rs2;
    push_entry.rd      = in_if.in_rd;
    push_entry.use_imm = in_if.in_use_imm;
    push_entry.imm     = in_if.in_imm;
  end

  alu_issue_fifo u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .data_i (push_entry),
    .pop_i  (pop),
    .head_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  // pend_rd is never 0 while pend_valid, so x0 reads never match.
  assign hit_a = pend_valid_q && (head.rs1 != '0) && (head.rs1 == pend_rd_q);
  assign hit_b = pend_valid_q && !head.use_imm && (head.rs2 != '0) &&
                 (head.rs2 == pend_rd_q);

`ifdef ALU_ISSUE_FWD_EN
  assign stall  = 1'b0;
  assign opnd_a = (head.rs1 == '0) ? '0 : (hit_a ? alu_result : rf_q[head.rs1]);
  assign opnd_b = head.use_imm ? head.imm :
                  (head.rs2 == '0) ? '0 : (hit_b ? alu_result : rf_q[head.rs2]);
`else
  // The register file write of pend_rd lands at the end of this cycle, so a
  // dependent op waits one cycle and then reads the written value.
  assign stall  = hit_a || hit_b;
  assign opnd_a = (head.rs1 == '0) ? '0 : rf_q[head.rs1];
  assign opnd_b = head.use_imm ? head.imm :
                  (head.rs2 == '0) ? '0 : rf_q[head.rs2];
`endif

  assign pop = !empty && !stall;

  // Operand/command outputs are zeroed when nothing issues.
  always_comb begin
    alu_valid   = 1'b0;
    alu_command = '0;
    alu_in_a    = '0;
    alu_in_b    = '0;
    if (pop) begin
      alu_valid   = 1'b1;
      alu_command = head.command;
      alu_in_a    = opnd_a;
      alu_in_b    = opnd_b;
    end
  end

  assign pend_valid_d = pop && (head.rd != '0);
  assign pend_rd_d    = pend_valid_d ? head.rd : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_rd_q    <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
    end
  end

  // ---- writeback stage: result of the op issued last cycle ----
  // A reset arriving while an op is in flight squashes its writeback.
  assign wb_valid = pend_valid_q && !reset;
  assign wb_rd    = pend_rd_q;
  assign wb_data  = alu_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (pend_valid_q && (pend_rd_q != '0)) begin
      rf_q[pend_rd_q] <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
  import common::*;

  localparam int XLEN = 32;
`ifdef ALU_ISSUE_FWD_EN
  localparam int DEP_GAP = 1;
  localparam int EXP_BP  = 0;
`else
  localparam int DEP_GAP = 2;
  localparam int EXP_BP  = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_issue_if #(.XLEN(XLEN)) bus ();

  logic            alu_valid;
  logic [2:0]      alu_command;
  logic [XLEN-1:0] alu_in_a, alu_in_b, alu_result;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  alu_issue #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_if      (bus),
    .alu_valid  (alu_valid),
    .alu_command(alu_command),
    .alu_in_a   (alu_in_a),
    .alu_in_b   (alu_in_b),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  alu #(.XLEN(XLEN)) u_alu (
    .clk    (clk),
    .reset  (reset),
    .valid  (alu_valid),
    .command(alu_command),
    .in_a   (alu_in_a),
    .in_b   (alu_in_b),
    .result (alu_result)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  issue_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  waited_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: records issue cycles and scores every writeback against exp_q.
  always @(negedge clk) begin
    cyc++;
    if (alu_valid) issue_q.push_back(cyc);
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: got rd=%0d data=0x%08h expected no writeback",
                 wb_rd, wb_data);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic send(input logic [2:0] cmd, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic use_imm, input logic [31:0] imm,
                      input logic [31:0] exp_data, input bit expect_wb);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_command = cmd;
    bus.in_rd      = rd;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_use_imm = use_imm;
    bus.in_imm     = imm;
    bus.in_valid   = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    waited_total += n;
    if (n == 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end else if (expect_wb) begin
      exp_q.push_back('{rd, exp_data});
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending writebacks expected 0", exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    bus.in_valid   = 1'b0;
    bus.in_command = '0;
    bus.in_rd      = '0;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_use_imm = 1'b0;
    bus.in_imm     = '0;

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_alu_valid", {31'd0, alu_valid}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_alu_command", {29'd0, alu_command}, 32'd0);
    chk("rst_alu_in_a", alu_in_a, 32'd0);
    chk("rst_alu_in_b", alu_in_b, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    send(ALU_ADD, 5'd1, 5'd5, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    drain();

    // Immediate, back-to-back dependent pair
    issue_q.delete();
    send(ALU_ADD, 5'd1, 5'd0, 5'd0, 1'b1, 32'd7, 32'd7, 1'b1);
    send(ALU_ADD, 5'd2, 5'd1, 5'd0, 1'b1, 32'd3, 32'd10, 1'b1);
    drain();
    chk("imm_issue_count", issue_q.size(), 32'd2);
    if (issue_q.size() >= 2) chk("imm_issue_gap", issue_q[1] - issue_q[0], DEP_GAP);

    // SUB / AND / OR on register operands
    send(ALU_ADD, 5'd1, 5'd0, 5'd0, 1'b1, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 1'b1);
    send(ALU_ADD, 5'd2, 5'd0, 5'd0, 1'b1, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 1'b1);
    send(ALU_SUB, 5'd3, 5'd1, 5'd2, 1'b0, 32'd0, 32'hE100_E100, 1'b1);
    send(ALU_AND, 5'd4, 5'd1, 5'd2, 1'b0, 32'd0, 32'h00F0_00F0, 1'b1);
    send(ALU_OR,  5'd5, 5'd1, 5'd2, 1'b0, 32'd0, 32'hFFF0_FFF0, 1'b1);
    drain();

    // x0 destination: no writeback; a following x0 reader never stalls
    issue_q.delete();
    send(ALU_ADD, 5'd0, 5'd0, 5'd0, 1'b1, 32'd5, 32'd0, 1'b0);
    send(ALU_ADD, 5'd7, 5'd0, 5'd0, 1'b1, 32'd9, 32'd9, 1'b1);
    drain();
    chk("x0_issue_count", issue_q.size(), 32'd2);
    if (issue_q.size() >= 2) chk("x0_issue_gap", issue_q[1] - issue_q[0], 32'd1);

    // Backpressure: dependent chain into x8
    waited_total = 0;
    send(ALU_ADD, 5'd8, 5'd0, 5'd0, 1'b1, 32'd1, 32'd1, 1'b1);
    send(ALU_ADD, 5'd8, 5'd8, 5'd0, 1'b1, 32'd1, 32'd2, 1'b1);
    send(ALU_ADD, 5'd8, 5'd8, 5'd0, 1'b1, 32'd1, 32'd3, 1'b1);
    send(ALU_ADD, 5'd8, 5'd8, 5'd0, 1'b1, 32'd1, 32'd4, 1'b1);
    drain();
    chk("bp_in_ready_dropped", {31'd0, (waited_total > 0)}, EXP_BP);

    // Reset during issue of an op to x6
    send(ALU_ADD, 5'd6, 5'd0, 5'd0, 1'b1, 32'h55, 32'd0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!alu_valid && n < 20);
    chk("rst_mid_issue_seen", {31'd0, alu_valid}, 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
    send(ALU_ADD, 5'd9, 5'd6, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    drain();

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage sitting directly upstream of the execute-stage `alu`. It accepts decoded ALU operations through a valid/ready handshake and buffers them in a 2-entry FIFO. It reads operands from an internal 32x32 register file, resolves read-after-write hazards against the op currently in the ALU, and drives the ALU's `valid`/`command`/`in_a`/`in_b`. It captures the ALU's registered `result` one cycle later and writes it back to the register file.

## Interface
- `XLEN`, 32, datapath width (must match ALU width)
- `NREGS`, 32, register file entries; index 0 hardwired to zero

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset; synchronous, active-high
- `in_valid`  in  1  decoded op offered
- `in_ready`  out  1  FIFO can accept (registered, `!full`)
- `in_command`  in  3  ALU opcode, `alu_op_t`
- `in_rs1`, `in_rs2`, `in_rd`  in  5 each  source/destination register indices
- `in_use_imm`  in  1  1: operand B = `in_imm`; 0: operand B = rs2
- `in_imm`  in  XLEN  immediate
- `alu_valid`  out  1  to ALU `valid`
- `alu_command`  out  3  to ALU `command`
- `alu_in_a`, `alu_in_b`  out  XLEN  to ALU operands
- `alu_result`  in  XLEN  from ALU `result` (registered by the ALU)
- `wb_valid`  out  1  writeback this cycle
- `wb_rd`  out  5  writeback index
- `wb_data`  out  XLEN  writeback data (= `alu_result`)

## Operation
- **Input:** handshake completes when `in_valid && in_ready`; the op is pushed into the FIFO tail. There is no combinational path from `in_valid` to `alu_valid`.
- **FIFO:** 2 entries with pointer wrap. Push and pop in the same cycle are legal when not full; a push is never accepted while full, even if a pop occurs that cycle.
- **Issue:**
  - The head op issues (`alu_valid=1`, pop) when the FIFO is non-empty and no stall is required.
  - `alu_in_a` = operand(rs1).
  - `alu_in_b` = `in_imm` if `use_imm`, else operand(rs2).
  - `alu_valid=0` when the FIFO is empty or stalled. Operand outputs are don't-care while `alu_valid=0`.
- **In-flight tracker:** registers `pend_valid`, `pend_rd`. They are set in the cycle after an issue whose rd≠0; otherwise cleared.
- **Writeback:**
  - `wb_valid = pend_valid`, `wb_rd = pend_rd`, `wb_data = alu_result`.
  - The register file is written at the end of that cycle.
  - Writes to index 0 are suppressed.
- **Operand read:** rs=0 yields 0. On a match rs == `pend_rd` with `pend_valid`, the hazard is handled per `ALU_ISSUE_FWD_EN`. Otherwise the register file value is used.
- **Commands:** passed through unmodified, including undefined encodings; the ALU defaults those to ADD.
- **Reset:**
  - Clears the FIFO, `pend_valid`, and all register file entries to 0.
  - Outputs after reset: `in_ready=1`, `alu_valid=0`, `alu_command=0`, `alu_in_a=0`, `alu_in_b=0`, `wb_valid=0`, `wb_rd=0`.
  - Reset asserted mid-operation discards buffered and in-flight ops; no writeback occurs for them.

## Timing
- Latency: handshake accepted in cycle N → earliest issue in N+1 → `wb_valid` in N+2 → register file updated at the end of N+2.
- Throughput: 1 op/cycle with forwarding compiled in.
- Without forwarding, a dependent op stalls exactly 1 cycle and issues in the cycle after writeback, reading the written value.
- A register file read of an index being written in the same cycle returns the old value; the hazard logic covers that case.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: on a hazard match, the operand is taken from `alu_result`, with no stall.
- `ALU_ISSUE_FWD_EN` undefined: on a hazard match, the head op is held (`alu_valid=0`) for that cycle, and `pend_valid` clears. The op issues next cycle from the register file.

## Structure
- Package `common`:
  - `alu_op_t` encodings (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB), as shared with `alu`.
  - New `issue_entry_t` packed struct: `command`, `rs1`, `rs2`, `rd`, `use_imm`, `imm`.
  - `REG_IDX_W = 5`.
- Sub-module `alu_issue_fifo`: 2-entry FIFO of `issue_entry_t` with `full`/`empty`.
- The register file and hazard logic are in the top level.
- Bench instantiates `alu_issue` together with `alu`.

## Test plan
- **Reset:** hold reset 2 cycles, then release → `in_ready=1`, `alu_valid=0`, `wb_valid=0`; reading x5 via ADD x1,x5,x0 writes back 0.
- **Immediate:** ADD rd=1, rs1=0, imm=7; then ADD rd=2, rs1=1, imm=3 back-to-back.
  - With FWD: issued on consecutive cycles; x2=10.
  - Without FWD: one bubble; x2=10.
- **SUB/AND/OR:** with x1=0xF0F0_F0F0 and x2=0x0FF0_0FF0:
  - SUB rd=3 → 0xE100_E100
  - AND rd=4 → 0x00F0_00F0
  - OR rd=5 → 0xFFF0_FFF0
- **x0:** ADD rd=0, imm=5 → `wb_valid=0`; a following op reading x0 sees 0 with no stall in either configuration.
- **Backpressure:** stall issue (dependent chain, no FWD) while offering 3 ops → `in_ready=0` after 2 are buffered; the third is accepted only after a pop; all 3 write back in order.
- **Reset mid-operation:** assert reset the cycle after an issue to rd=6 → `wb_valid` stays 0; x6 reads 0 afterwards.
